// File: rtl/mem_rs_agu_pkg.sv
// Shared types for the memory reservation station and its address-generation stage.
package mem_rs_agu_pkg;

    localparam int PRF_IDX          = 6;
    localparam int ROB_IDX          = 5;
    localparam int MEM_RS_DEPTH_DEF = 8;

    // Memory opcodes: bit3 = store, bit2 = unsigned, [1:0] = access size (0 B, 1 H, 2 W)
    typedef enum logic [3:0] {
        MEM_LB  = 4'b0000,
        MEM_LH  = 4'b0001,
        MEM_LW  = 4'b0010,
        MEM_LBU = 4'b0100,
        MEM_LHU = 4'b0101,
        MEM_SB  = 4'b1000,
        MEM_SH  = 4'b1001,
        MEM_SW  = 4'b1010
    } mem_op_e;

    typedef struct packed {
        logic               valid;
        logic [ROB_IDX-1:0] rob_id;
        logic [3:0]         fu_opcode;
        logic [PRF_IDX-1:0] rs1_phy;
        logic               rs1_rdy;
        logic [PRF_IDX-1:0] rs2_phy;
        logic               rs2_rdy;
        logic [31:0]        imm;
    } mem_rs_entry_t;

    typedef struct packed {
        logic               valid;
        logic [ROB_IDX-1:0] rob_id;
        logic [31:0]        addr;
        logic [3:0]         mask;
        logic [31:0]        wdata;
        logic [31:0]        rs1_value;
        logic [31:0]        rs2_value;
    } agu_lsq_t;

    function automatic logic opIsStore(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic [1:0] opSize(input logic [3:0] op);
        return op[1:0];
    endfunction

    // Physical tag 0 is hardwired ready, so a broadcast on it never counts as a wakeup
    function automatic logic tagWake(input logic cdbValid,
                                     input logic [PRF_IDX-1:0] cdbTag,
                                     input logic [PRF_IDX-1:0] tag);
        return cdbValid && (cdbTag == tag) && (tag != '0);
    endfunction

endpackage

// File: rtl/mem_rs_agu_if.sv
// Dispatch, CDB, PRF read and AGU result signals of the memory reservation station.
interface mem_rs_agu_if;
    import mem_rs_agu_pkg::*;

    logic               flush;
    logic               ds_valid;
    logic               ds_ready;
    logic [ROB_IDX-1:0] ds_rob_id;
    logic [3:0]         ds_fu_opcode;
    logic [PRF_IDX-1:0] ds_rs1_phy;
    logic               ds_rs1_rdy;
    logic [PRF_IDX-1:0] ds_rs2_phy;
    logic               ds_rs2_rdy;
    logic [31:0]        ds_imm;
    logic               cdb_valid;
    logic [PRF_IDX-1:0] cdb_rd_phy;
    logic [PRF_IDX-1:0] prf_rs1_phy;
    logic [PRF_IDX-1:0] prf_rs2_phy;
    logic [31:0]        prf_rs1_value;
    logic [31:0]        prf_rs2_value;
    logic               agu_valid;
    logic [ROB_IDX-1:0] agu_rob_id;
    logic [31:0]        agu_addr;
    logic [3:0]         agu_mask;
    logic [31:0]        agu_wdata;
    logic [31:0]        agu_rs1_value_dbg;
    logic [31:0]        agu_rs2_value_dbg;

    // Backend side: dispatch, CDB, PRF data, consumes AGU results
    modport master (
        output flush, ds_valid, ds_rob_id, ds_fu_opcode, ds_rs1_phy, ds_rs1_rdy,
               ds_rs2_phy, ds_rs2_rdy, ds_imm, cdb_valid, cdb_rd_phy,
               prf_rs1_value, prf_rs2_value,
        input  ds_ready, prf_rs1_phy, prf_rs2_phy, agu_valid, agu_rob_id, agu_addr,
               agu_mask, agu_wdata, agu_rs1_value_dbg, agu_rs2_value_dbg
    );

    // Reservation station side
    modport slave (
        input  flush, ds_valid, ds_rob_id, ds_fu_opcode, ds_rs1_phy, ds_rs1_rdy,
               ds_rs2_phy, ds_rs2_rdy, ds_imm, cdb_valid, cdb_rd_phy,
               prf_rs1_value, prf_rs2_value,
        output ds_ready, prf_rs1_phy, prf_rs2_phy, agu_valid, agu_rob_id, agu_addr,
               agu_mask, agu_wdata, agu_rs1_value_dbg, agu_rs2_value_dbg
    );

endinterface

// File: rtl/mem_rs_agu_agu.sv
// Combinational address generation: byte address, byte-enable mask and lane-aligned store data.
module mem_agu
    import mem_rs_agu_pkg::*;
(
    input  logic [3:0]  opcode_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] addr_o,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o
);

    logic [31:0] addrSum;
    logic [31:0] laneData;

    // Mask and data shift follow the low address bits; misaligned accesses are not trapped here
    always_comb begin
        addrSum  = rs1_i + imm_i;
        mask_o   = 4'b1111;
        laneData = rs2_i;
        case (opSize(opcode_i))
            2'd0: begin
                mask_o   = 4'b0001 << addrSum[1:0];
                laneData = rs2_i << {addrSum[1:0], 3'b000};
            end
            2'd1: begin
                mask_o   = 4'b0011 << {addrSum[1], 1'b0};
                laneData = rs2_i << {addrSum[1], 4'b0000};
            end
            default: begin
                mask_o   = 4'b1111;
                laneData = rs2_i;
            end
        endcase
        addr_o  = addrSum;
        wdata_o = opIsStore(opcode_i) ? laneData : 32'd0;
    end

endmodule

// File: rtl/mem_rs_agu.sv
// Memory-op reservation station with CDB wakeup, single issue per cycle and a registered AGU stage.
module mem_rs_agu
    import mem_rs_agu_pkg::*;
#(
    parameter int MEM_RS_DEPTH = MEM_RS_DEPTH_DEF
) (
    input logic          clk,
    input logic          rst_n,
    mem_rs_agu_if.slave  rs_if
);

    localparam int IDX_W = (MEM_RS_DEPTH > 1) ? $clog2(MEM_RS_DEPTH) : 1;

    mem_rs_entry_t entry_q [MEM_RS_DEPTH];
    mem_rs_entry_t entry_d [MEM_RS_DEPTH];
    agu_lsq_t      agu_q;
    agu_lsq_t      agu_d;

    logic             freeFound;
    logic [IDX_W-1:0] freeIdx;
    logic             selFound;
    logic [IDX_W-1:0] selIdx;
    mem_rs_entry_t    selEntry;
    logic [31:0]      aguAddr;
    logic [3:0]       aguMask;
    logic [31:0]      aguWdata;

    // Lowest free slot for allocation and lowest fully-ready slot for issue, both from registered state
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        selFound  = 1'b0;
        selIdx    = '0;
        for (int i = MEM_RS_DEPTH - 1; i >= 0; i--) begin
            if (!entry_q[i].valid) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
            if (entry_q[i].valid && entry_q[i].rs1_rdy && entry_q[i].rs2_rdy) begin
                selFound = 1'b1;
                selIdx   = IDX_W'(i);
            end
        end
        selEntry = entry_q[selIdx];
    end

    assign rs_if.ds_ready    = freeFound;
    assign rs_if.prf_rs1_phy = selEntry.rs1_phy;
    assign rs_if.prf_rs2_phy = selEntry.rs2_phy;

    mem_agu u_agu (
        .opcode_i (selEntry.fu_opcode),
        .rs1_i    (rs_if.prf_rs1_value),
        .rs2_i    (rs_if.prf_rs2_value),
        .imm_i    (selEntry.imm),
        .addr_o   (aguAddr),
        .mask_o   (aguMask),
        .wdata_o  (aguWdata)
    );

    // Entry update: wakeup, free the issuing slot, allocate with same-cycle CDB bypass, flush wins
    always_comb begin
        for (int i = 0; i < MEM_RS_DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].valid) begin
                if (tagWake(rs_if.cdb_valid, rs_if.cdb_rd_phy, entry_q[i].rs1_phy)) begin
                    entry_d[i].rs1_rdy = 1'b1;
                end
                if (tagWake(rs_if.cdb_valid, rs_if.cdb_rd_phy, entry_q[i].rs2_phy)) begin
                    entry_d[i].rs2_rdy = 1'b1;
                end
            end
        end
        if (selFound) begin
            entry_d[selIdx].valid = 1'b0;
        end
        if (rs_if.ds_valid && freeFound) begin
            entry_d[freeIdx].valid     = 1'b1;
            entry_d[freeIdx].rob_id    = rs_if.ds_rob_id;
            entry_d[freeIdx].fu_opcode = rs_if.ds_fu_opcode;
            entry_d[freeIdx].rs1_phy   = rs_if.ds_rs1_phy;
            entry_d[freeIdx].rs2_phy   = rs_if.ds_rs2_phy;
            entry_d[freeIdx].imm       = rs_if.ds_imm;
            entry_d[freeIdx].rs1_rdy   = rs_if.ds_rs1_rdy || (rs_if.ds_rs1_phy == '0) ||
                                         tagWake(rs_if.cdb_valid, rs_if.cdb_rd_phy, rs_if.ds_rs1_phy);
            entry_d[freeIdx].rs2_rdy   = rs_if.ds_rs2_rdy || (rs_if.ds_rs2_phy == '0) ||
                                         tagWake(rs_if.cdb_valid, rs_if.cdb_rd_phy, rs_if.ds_rs2_phy);
        end
        if (rs_if.flush) begin
            for (int i = 0; i < MEM_RS_DEPTH; i++) begin
                entry_d[i].valid = 1'b0;
            end
        end
    end

    // AGU pipeline register: one-cycle pulse per issued uop, data held while idle
    always_comb begin
        agu_d       = agu_q;
        agu_d.valid = 1'b0;
        if (selFound && !rs_if.flush) begin
            agu_d.valid     = 1'b1;
            agu_d.rob_id    = selEntry.rob_id;
            agu_d.addr      = aguAddr;
            agu_d.mask      = aguMask;
            agu_d.wdata     = aguWdata;
            agu_d.rs1_value = rs_if.prf_rs1_value;
            agu_d.rs2_value = rs_if.prf_rs2_value;
        end
    end

    // State registers; reset empties the station and zeroes the AGU outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_RS_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            agu_q <= '0;
        end else begin
            for (int i = 0; i < MEM_RS_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            agu_q <= agu_d;
        end
    end

    assign rs_if.agu_valid         = agu_q.valid;
    assign rs_if.agu_rob_id        = agu_q.rob_id;
    assign rs_if.agu_addr          = agu_q.addr;
    assign rs_if.agu_mask          = agu_q.mask;
    assign rs_if.agu_wdata         = agu_q.wdata;
    assign rs_if.agu_rs1_value_dbg = agu_q.rs1_value;
    assign rs_if.agu_rs2_value_dbg = agu_q.rs2_value;

endmodule
